// File: rtl/execute_muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Optional macro RAPID_FAST_MUL_EN: multiplies use one signed hard multiply with latency 1.
module execute_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [4:0]      i_rd,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic [4:0]      o_rd,
    output logic            o_busy
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [2:0]         r_op;
    logic [4:0]         r_rd_lat;
    logic               r_neg;
    logic [XLEN-1:0]    r_opnd;
    logic [XLEN-1:0]    r_hi;
    logic [XLEN-1:0]    r_lo;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_valid;
    logic [XLEN-1:0]    r_result;
    logic [4:0]         r_rd;

    // ---------------- accept-time decode ----------------
    logic               w_accept;
    logic               w_is_div;
    logic               w_a_signed;
    logic               w_b_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [XLEN-1:0]    w_abs_a;
    logic [XLEN-1:0]    w_abs_b;
    logic               w_neg_res;
    logic               w_div_zero;
    logic               w_ovf;
    logic               w_direct;
    logic [XLEN-1:0]    w_direct_res;

    assign w_accept   = i_valid && (r_state == S_IDLE) && !i_flush;
    assign w_is_div   = i_op[2];
    assign w_a_signed = (i_op == OP_MULH) || (i_op == OP_MULHSU) || (i_op == OP_DIV) || (i_op == OP_REM);
    assign w_b_signed = (i_op == OP_MULH) || (i_op == OP_DIV) || (i_op == OP_REM);
    assign w_a_neg    = w_a_signed && i_rs1[XLEN-1];
    assign w_b_neg    = w_b_signed && i_rs2[XLEN-1];
    assign w_abs_a    = w_a_neg ? (-i_rs1) : i_rs1;
    assign w_abs_b    = w_b_neg ? (-i_rs2) : i_rs2;
    // Remainder takes the dividend's sign; everything else the product/quotient sign.
    assign w_neg_res  = (i_op == OP_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);
    assign w_div_zero = w_is_div && (i_rs2 == '0);
    assign w_ovf      = ((i_op == OP_DIV) || (i_op == OP_REM))
                        && (i_rs1 == {1'b1, {(XLEN-1){1'b0}}})
                        && (i_rs2 == '1);

`ifdef RAPID_FAST_MUL_EN
    logic signed [XLEN:0]     w_fa;
    logic signed [XLEN:0]     w_fb;
    logic signed [2*XLEN-1:0] w_fp;

    assign w_fa = {w_a_signed && i_rs1[XLEN-1], i_rs1};
    assign w_fb = {w_b_signed && i_rs2[XLEN-1], i_rs2};
    assign w_fp = w_fa * w_fb;
`endif

    always_comb begin
        w_direct     = 1'b0;
        w_direct_res = '0;
        if (w_div_zero) begin
            w_direct     = 1'b1;
            w_direct_res = i_op[1] ? i_rs1 : '1;
        end else if (w_ovf) begin
            w_direct     = 1'b1;
            w_direct_res = i_op[1] ? '0 : i_rs1;
        end
`ifdef RAPID_FAST_MUL_EN
        else if (!w_is_div) begin
            w_direct     = 1'b1;
            w_direct_res = (i_op == OP_MUL) ? w_fp[XLEN-1:0] : w_fp[2*XLEN-1:XLEN];
        end
`endif
    end

    // ---------------- iteration step ----------------
    // Multiply: r_hi accumulates, r_lo holds the multiplier and collects the low product bits.
    // Divide:   r_hi is the partial remainder, r_lo shifts the dividend out and quotient bits in.
    logic [XLEN:0]      w_mul_sum;
    logic [XLEN-1:0]    w_mul_hi;
    logic [XLEN-1:0]    w_mul_lo;
    logic [XLEN:0]      w_div_shift;
    logic [XLEN:0]      w_div_diff;
    logic               w_div_ge;
    logic [XLEN-1:0]    w_div_hi;
    logic [XLEN-1:0]    w_div_lo;
    logic [XLEN-1:0]    w_step_hi;
    logic [XLEN-1:0]    w_step_lo;
    logic               w_last;

    assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_hi    = w_mul_sum[XLEN:1];
    assign w_mul_lo    = {w_mul_sum[0], r_lo[XLEN-1:1]};
    assign w_div_shift = {r_hi, r_lo[XLEN-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
    assign w_div_ge    = !w_div_diff[XLEN];
    assign w_div_hi    = w_div_ge ? w_div_diff[XLEN-1:0] : w_div_shift[XLEN-1:0];
    assign w_div_lo    = {r_lo[XLEN-2:0], w_div_ge};
    assign w_step_hi   = r_op[2] ? w_div_hi : w_mul_hi;
    assign w_step_lo   = r_op[2] ? w_div_lo : w_mul_lo;
    assign w_last      = (r_state == S_CALC) && (r_cnt == CNT_W'(XLEN - 1));

    // ---------------- sign fix and result select ----------------
    logic [2*XLEN-1:0]  w_prod_fix;
    logic [XLEN-1:0]    w_quo_fix;
    logic [XLEN-1:0]    w_rem_fix;
    logic [XLEN-1:0]    w_calc_res;

    assign w_prod_fix = r_neg ? (-{w_step_hi, w_step_lo}) : {w_step_hi, w_step_lo};
    assign w_quo_fix  = r_neg ? (-w_step_lo) : w_step_lo;
    assign w_rem_fix  = r_neg ? (-w_step_hi) : w_step_hi;

    always_comb begin
        w_calc_res = '0;
        case (r_op)
            OP_MUL:           w_calc_res = w_prod_fix[XLEN-1:0];
            3'b001, 3'b010,
            3'b011:           w_calc_res = w_prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:   w_calc_res = w_quo_fix;
            default:          w_calc_res = w_rem_fix;
        endcase
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (i_flush) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (i_valid) w_state_next = w_direct ? S_DONE : S_CALC;
                S_CALC: if (w_last)  w_state_next = S_DONE;
                S_DONE: if (i_ready) w_state_next = S_IDLE;
                default:             w_state_next = S_IDLE;
            endcase
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_op     <= '0;
            r_rd_lat <= '0;
            r_neg    <= 1'b0;
            r_opnd   <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_result <= '0;
            r_rd     <= '0;
        end else begin
            r_valid <= (w_state_next == S_DONE);
            if (w_accept) begin
                r_op     <= i_op;
                r_rd_lat <= i_rd;
                r_neg    <= w_neg_res;
                r_cnt    <= '0;
                r_hi     <= '0;
                r_opnd   <= w_is_div ? w_abs_b : w_abs_a;
                r_lo     <= w_is_div ? w_abs_a : w_abs_b;
                if (w_direct) begin
                    r_result <= w_direct_res;
                    r_rd     <= i_rd;
                end
            end else if (r_state == S_CALC) begin
                r_cnt <= r_cnt + CNT_W'(1);
                r_hi  <= w_step_hi;
                r_lo  <= w_step_lo;
                if (w_last && !i_flush) begin
                    r_result <= w_calc_res;
                    r_rd     <= r_rd_lat;
                end
            end
        end
    end

    assign o_ready  = (r_state == S_IDLE);
    assign o_busy   = (r_state != S_IDLE);
    assign o_valid  = r_valid;
    assign o_result = r_result;
    assign o_rd     = r_rd;

endmodule
